// File: rtl/data_mem_access.sv
// -----------------------------------------------------------------------------
// data_mem_access
//
// Byte-serial data-memory access unit. It accepts one load or store request
// per transaction and splits it into 1/2/4 little-endian byte transfers on a
// shared 8-bit RAM port. Loads return a zero-extended word with a one-cycle
// dataValid pulse. Stores end with a one-cycle dataWriteSuc pulse. The port
// is requested with memReq, and a byte moves only in cycles where memGrant
// was high at the sampling edge.
//
// Ports
//   clockIn       : clock; all state changes on its rising edge
//   resetIn       : synchronous reset, active-low
//   clearIn       : pipeline flush; aborts loads, lets stores finish
//   accessType    : 00 none, 01 byte, 10 half, 11 word (valid one cycle)
//   readWriteIn   : 1 = load, 0 = store
//   dataAddr      : request byte address
//   dataOut       : store data; byte k = dataOut[8k+7:8k]
//   dataValid     : one-cycle pulse, load result on dataIn
//   dataIn        : assembled load data, zero-extended
//   dataWriteSuc  : one-cycle pulse, store fully written
//   memReq        : bus request to the external arbiter
//   memGrant      : arbiter grant for the current cycle
//   memAddr       : RAM byte address
//   memWrite      : 1 = write memDataOut this cycle
//   memDataOut    : RAM write byte
//   memDataIn     : RAM read byte, valid one cycle after its address
//   ioBufferFull  : IO write sink full; stalls stores to the IO window
// -----------------------------------------------------------------------------
module data_mem_access (
  input  logic        clockIn,
  input  logic        resetIn,
  input  logic        clearIn,
  input  logic [1:0]  accessType,
  input  logic        readWriteIn,
  input  logic [31:0] dataAddr,
  input  logic [31:0] dataOut,
  output logic        dataValid,
  output logic [31:0] dataIn,
  output logic        dataWriteSuc,
  output logic        memReq,
  input  logic        memGrant,
  output logic [31:0] memAddr,
  output logic        memWrite,
  output logic [7:0]  memDataOut,
  input  logic [7:0]  memDataIn,
  input  logic        ioBufferFull
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;

  // Latched request
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [2:0]  req_len;

  // Byte bookkeeping
  logic [2:0]  issue_cnt;   // bytes put on the bus so far
  logic [2:0]  capt_cnt;    // load bytes captured so far
  logic [31:0] load_buf;    // partially assembled load word
  // A read byte returns two edges after it is issued. pend_1 and pend_2
  // track issued reads through that return path.
  logic        pend_1;
  logic        pend_2;

  // Decoded request and per-cycle decisions
  logic [2:0]  req_size;
  logic        can_accept;
  logic        accept_load;
  logic        accept_store;
  logic        io_stall;
  logic        rd_issue;
  logic        wr_issue;
  logic        rd_capture;
  logic        rd_last;
  logic [31:0] issue_addr;
  logic [7:0]  store_byte;
  logic [31:0] captured_word;

  // NOTE: every signal assigned in always_comb gets a default value first,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    req_size = 3'd0;
    case (accessType)
      2'b01:   req_size = 3'd1;
      2'b10:   req_size = 3'd2;
      2'b11:   req_size = 3'd4;
      default: req_size = 3'd0;
    endcase
  end

  // A flush drops a load that arrives in the same cycle. A store arriving
  // in that cycle is still taken.
  assign can_accept   = (state == IDLE) || (state == DONE);
  assign accept_load  = can_accept && (req_size != 3'd0) && readWriteIn && !clearIn;
  assign accept_store = can_accept && (req_size != 3'd0) && !readWriteIn;

  // Stores into the IO window (address bits [17:16] == 11) wait while the
  // IO sink is full. memReq stays asserted during the wait.
  assign io_stall   = (req_addr[17:16] == 2'b11) && ioBufferFull;

  assign rd_issue   = (state == READ)  && !clearIn && memGrant && (issue_cnt < req_len);
  assign wr_issue   = (state == WRITE) && memGrant && !io_stall && (issue_cnt < req_len);
  assign rd_capture = (state == READ)  && !clearIn && pend_2;
  assign rd_last    = rd_capture && (capt_cnt == req_len - 3'd1);

  // Byte addresses wrap naturally at 32 bits. Misaligned requests are legal.
  assign issue_addr = req_addr + {29'd0, issue_cnt};

  always_comb begin
    store_byte = req_data[7:0];
    case (issue_cnt[1:0])
      2'd0:    store_byte = req_data[7:0];
      2'd1:    store_byte = req_data[15:8];
      2'd2:    store_byte = req_data[23:16];
      default: store_byte = req_data[31:24];
    endcase
  end

  // load_buf is cleared at accept, so OR-ing in each byte leaves the bytes
  // above the access size at zero.
  assign captured_word = load_buf | ({24'd0, memDataIn} << {capt_cnt, 3'b000});

  // NOTE: sequential state uses non-blocking assignments only. Every
  // register then samples pre-edge values, whatever order the statements
  // appear in below.
  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      state        <= IDLE;
      req_addr     <= 32'd0;
      req_data     <= 32'd0;
      req_len      <= 3'd0;
      issue_cnt    <= 3'd0;
      capt_cnt     <= 3'd0;
      load_buf     <= 32'd0;
      pend_1       <= 1'b0;
      pend_2       <= 1'b0;
      dataValid    <= 1'b0;
      dataIn       <= 32'd0;
      dataWriteSuc <= 1'b0;
      memReq       <= 1'b0;
      memAddr      <= 32'd0;
      memWrite     <= 1'b0;
      memDataOut   <= 8'd0;
    end else begin
      // Pulse outputs and the write strobe last one cycle unless set below.
      dataValid    <= 1'b0;
      dataWriteSuc <= 1'b0;
      memWrite     <= 1'b0;
      pend_1       <= rd_issue;
      pend_2       <= pend_1;

      case (state)
        IDLE, DONE: begin
          if (accept_load || accept_store) begin
            req_addr  <= dataAddr;
            req_data  <= dataOut;
            req_len   <= req_size;
            issue_cnt <= 3'd0;
            capt_cnt  <= 3'd0;
            load_buf  <= 32'd0;
            pend_2    <= 1'b0;
            memReq    <= 1'b1;
            state     <= accept_load ? READ : WRITE;
          end else begin
            memReq <= 1'b0;
            state  <= IDLE;
          end
        end

        READ: begin
          if (clearIn) begin
            // Abandon the load. Bytes still returning from the RAM are
            // ignored.
            pend_2 <= 1'b0;
            memReq <= 1'b0;
            state  <= IDLE;
          end else begin
            if (rd_issue) begin
              memAddr   <= issue_addr;
              issue_cnt <= issue_cnt + 3'd1;
            end
            if (rd_capture) begin
              load_buf <= captured_word;
              capt_cnt <= capt_cnt + 3'd1;
            end
            if (rd_last) begin
              dataIn    <= captured_word;
              dataValid <= 1'b1;
              memReq    <= 1'b0;
              state     <= DONE;
            end
          end
        end

        WRITE: begin
          // clearIn is deliberately ignored: stores always run to completion.
          if (issue_cnt == req_len) begin
            // Last byte was written at the previous edge.
            dataWriteSuc <= 1'b1;
            memReq       <= 1'b0;
            state        <= DONE;
          end else if (wr_issue) begin
            memAddr    <= issue_addr;
            memWrite   <= 1'b1;
            memDataOut <= store_byte;
            issue_cnt  <= issue_cnt + 3'd1;
          end
        end

        default: begin
          memReq <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_access.sv
// -----------------------------------------------------------------------------
// tb_data_mem_access
//
// Self-checking bench for data_mem_access. A behavioural RAM with one cycle
// of read latency sits on the byte port. A transaction-level model predicts,
// edge by edge, the bus issues, pulse timing and load word. The predictions
// come from grant/stall/flush rules applied to a count of issued bytes.
// -----------------------------------------------------------------------------
module tb_data_mem_access;

  logic        clockIn = 1'b0;
  logic        resetIn;
  logic        clearIn;
  logic [1:0]  accessType;
  logic        readWriteIn;
  logic [31:0] dataAddr;
  logic [31:0] dataOut;
  logic        dataValid;
  logic [31:0] dataIn;
  logic        dataWriteSuc;
  logic        memReq;
  logic        memGrant;
  logic [31:0] memAddr;
  logic        memWrite;
  logic [7:0]  memDataOut;
  logic [7:0]  memDataIn;
  logic        ioBufferFull;

  int          vectors = 0;
  int          miscompares = 0;
  int          done_edge;
  logic [31:0] obs_data;

  data_mem_access dut (
    .clockIn      (clockIn),
    .resetIn      (resetIn),
    .clearIn      (clearIn),
    .accessType   (accessType),
    .readWriteIn  (readWriteIn),
    .dataAddr     (dataAddr),
    .dataOut      (dataOut),
    .dataValid    (dataValid),
    .dataIn       (dataIn),
    .dataWriteSuc (dataWriteSuc),
    .memReq       (memReq),
    .memGrant     (memGrant),
    .memAddr      (memAddr),
    .memWrite     (memWrite),
    .memDataOut   (memDataOut),
    .memDataIn    (memDataIn),
    .ioBufferFull (ioBufferFull)
  );

  always #5 clockIn = ~clockIn;

  // Sparse byte RAM. Addresses that were never written return a pattern.
  logic [7:0] ram [logic [31:0]];

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  always @(posedge clockIn) begin
    if (memWrite) ram[memAddr] = memDataOut;
    memDataIn <= ram_rd(memAddr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction. Bit k-1 of gmask/iomask is the grant/IO-full value
  // sampled at edge k after the request edge. Past 32 edges, grant is held
  // high and IO is not full. clear_at (0 = never) raises clearIn for edge
  // clear_at. clr_req raises clearIn at the request edge itself.
  // done_edge returns the pulse edge, or -1.
  task automatic do_txn(input logic [1:0] sz, input logic is_load,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] gmask, input logic [31:0] iomask,
                        input int clear_at, input logic clr_req,
                        output int done_edge);
    int          n;
    int          issued;
    int          last;
    logic        store;
    logic        aborted;
    logic        io_space;
    logic        g;
    logic        io;
    logic        exp_issue;
    logic        exp_valid;
    logic        exp_suc;
    logic [31:0] exp_word;

    n        = (sz == 2'b01) ? 1 : (sz == 2'b10) ? 2 : 4;
    store    = !is_load;
    io_space = (addr[17:16] == 2'b11);
    exp_word = 32'd0;
    for (int i = 0; i < n; i++)
      exp_word |= {24'd0, ram_rd(addr + 32'(i))} << (8 * i);
    done_edge = -1;
    issued    = 0;
    last      = 0;
    aborted   = 1'b0;

    @(negedge clockIn);
    accessType   = sz;
    readWriteIn  = is_load;
    dataAddr     = addr;
    dataOut      = data;
    memGrant     = 1'b0;
    ioBufferFull = 1'b0;
    clearIn      = clr_req;
    @(posedge clockIn); #1;

    if (clr_req && is_load) begin
      check("flush_drops_load_req", {31'd0, memReq}, 32'd0);
      @(negedge clockIn);
      accessType = 2'b00;
      clearIn    = 1'b0;
      @(posedge clockIn); #1;
      check("dropped_load_no_valid", {31'd0, dataValid}, 32'd0);
      return;
    end
    check("accept_req", {31'd0, memReq}, 32'd1);

    for (int k = 1; k <= 64; k++) begin
      g  = (k <= 32) ? gmask[k-1]  : 1'b1;
      io = (k <= 32) ? iomask[k-1] : 1'b0;
      @(negedge clockIn);
      // Requests raised while busy must be ignored, so drive junk.
      accessType   = 2'($urandom_range(0, 3));
      readWriteIn  = 1'($urandom_range(0, 1));
      dataAddr     = $urandom();
      dataOut      = $urandom();
      clearIn      = (k == clear_at);
      memGrant     = g;
      ioBufferFull = io;
      if (is_load && (k == clear_at)) aborted = 1'b1;
      exp_issue = !aborted && (issued < n) && g && !(store && io_space && io);
      @(posedge clockIn); #1;

      check("mem_write", {31'd0, memWrite}, {31'd0, exp_issue && store});
      if (exp_issue) begin
        check("mem_addr", memAddr, addr + 32'(issued));
        if (store) check("mem_wdata", {24'd0, memDataOut}, {24'd0, 8'(data >> (8 * issued))});
        issued++;
        if (issued == n) last = k;
      end
      exp_valid = is_load && !aborted && (issued == n) && (k == last + 2);
      exp_suc   = store && (issued == n) && (k == last + 1);
      check("data_valid", {31'd0, dataValid}, {31'd0, exp_valid});
      check("write_suc", {31'd0, dataWriteSuc}, {31'd0, exp_suc});
      check("mem_req", {31'd0, memReq}, {31'd0, !(exp_valid || exp_suc || aborted)});
      if (exp_valid) begin
        check("load_data", dataIn, exp_word);
        obs_data = dataIn;
      end
      if (exp_valid || exp_suc) begin
        done_edge = k;
        break;
      end
      if (aborted) break;
    end

    if (aborted) begin
      // In-flight bytes of the flushed load must never produce a result.
      repeat (3) begin
        @(negedge clockIn);
        accessType = 2'b00;
        clearIn    = 1'b0;
        memGrant   = 1'b1;
        @(posedge clockIn); #1;
        check("flush_no_valid", {31'd0, dataValid}, 32'd0);
        check("flush_idle_req", {31'd0, memReq}, 32'd0);
      end
    end else begin
      check("txn_completed", {31'd0, done_edge > 0}, 32'd1);
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(negedge clockIn);
      accessType = 2'b00;
      clearIn    = 1'b0;
      memGrant   = 1'($urandom_range(0, 1));
      @(posedge clockIn); #1;
      check("idle_req", {31'd0, memReq}, 32'd0);
      check("idle_write", {31'd0, memWrite}, 32'd0);
      check("idle_pulses", {30'd0, dataValid, dataWriteSuc}, 32'd0);
    end
  endtask

  initial begin
    logic [1:0]  sz;
    logic        ld;
    logic [31:0] addr;
    logic [31:0] gm;
    logic [31:0] im;
    int          clr;

    resetIn      = 1'b0;
    clearIn      = 1'b0;
    accessType   = 2'b00;
    readWriteIn  = 1'b0;
    dataAddr     = 32'd0;
    dataOut      = 32'd0;
    memGrant     = 1'b0;
    ioBufferFull = 1'b0;
    ram[32'h100] = 8'h11;
    ram[32'h101] = 8'h22;
    ram[32'h102] = 8'h33;
    ram[32'h103] = 8'h44;

    // Reset state
    repeat (3) @(posedge clockIn);
    #1;
    check("rst_valid", {31'd0, dataValid}, 32'd0);
    check("rst_suc", {31'd0, dataWriteSuc}, 32'd0);
    check("rst_data", dataIn, 32'd0);
    check("rst_req", {31'd0, memReq}, 32'd0);
    check("rst_write", {31'd0, memWrite}, 32'd0);
    check("rst_addr", memAddr, 32'd0);
    check("rst_wdata", {24'd0, memDataOut}, 32'd0);
    @(negedge clockIn);
    resetIn = 1'b1;
    idle(2);

    // Word load, full grant: valid at edge 6
    do_txn(2'b11, 1'b1, 32'h100, 32'd0, '1, 32'd0, 0, 1'b0, done_edge);
    check("word_load_latency", done_edge, 32'd6);
    check("word_load_value", obs_data, 32'h4433_2211);

    // Byte store, full grant: one write, success at edge 2
    do_txn(2'b01, 1'b0, 32'h2005, 32'hAABB_CCDD, '1, 32'd0, 0, 1'b0, done_edge);
    check("byte_store_latency", done_edge, 32'd2);
    check("byte_store_ram", {24'd0, ram_rd(32'h2005)}, 32'h0000_00DD);
    idle(1);

    // Half load across a 256-byte boundary, grant low at edges 1 and 3
    do_txn(2'b10, 1'b1, 32'h1FF, 32'd0, ~32'h5, 32'd0, 0, 1'b0, done_edge);
    check("half_load_latency", done_edge, 32'd6);
    check("half_load_upper_zero", {16'd0, obs_data[31:16]}, 32'd0);

    // Flushes: word load aborted at edge 3, word store runs on past a flush
    do_txn(2'b11, 1'b1, 32'h100, 32'd0, '1, 32'd0, 3, 1'b0, done_edge);
    check("flushed_load_no_pulse", done_edge, 32'hFFFF_FFFF);
    do_txn(2'b11, 1'b0, 32'h600, 32'h0102_0304, '1, 32'd0, 2, 1'b0, done_edge);
    check("flushed_store_latency", done_edge, 32'd5);

    // Flush in the request cycle: load dropped, store taken
    do_txn(2'b11, 1'b1, 32'h100, 32'd0, '1, 32'd0, 0, 1'b1, done_edge);
    do_txn(2'b10, 1'b0, 32'h700, 32'h0000_BEEF, '1, 32'd0, 0, 1'b1, done_edge);
    check("flush_store_taken", done_edge, 32'd3);

    // IO stall for 3 edges, then a back-to-back word load from DONE
    do_txn(2'b01, 1'b0, 32'h3_0000, 32'h0000_005A, '1, 32'h7, 0, 1'b0, done_edge);
    check("io_stall_latency", done_edge, 32'd5);
    do_txn(2'b11, 1'b1, 32'h500, 32'd0, '1, 32'd0, 0, 1'b0, done_edge);
    check("back_to_back_latency", done_edge, 32'd6);

    // Address wrap at the top of the 32-bit space
    do_txn(2'b11, 1'b1, 32'hFFFF_FFFE, 32'd0, '1, 32'd0, 0, 1'b0, done_edge);
    check("wrap_load_latency", done_edge, 32'd6);
    idle(1);

    // Reset in the middle of a word store
    @(negedge clockIn);
    accessType  = 2'b11;
    readWriteIn = 1'b0;
    dataAddr    = 32'h4000;
    dataOut     = 32'hCAFE_F00D;
    memGrant    = 1'b1;
    @(posedge clockIn);
    @(negedge clockIn);
    accessType = 2'b00;
    @(posedge clockIn);
    @(negedge clockIn);
    resetIn = 1'b0;
    @(posedge clockIn); #1;
    check("midrst_valid", {31'd0, dataValid}, 32'd0);
    check("midrst_suc", {31'd0, dataWriteSuc}, 32'd0);
    check("midrst_data", dataIn, 32'd0);
    check("midrst_req", {31'd0, memReq}, 32'd0);
    check("midrst_write", {31'd0, memWrite}, 32'd0);
    check("midrst_addr", memAddr, 32'd0);
    check("midrst_wdata", {24'd0, memDataOut}, 32'd0);
    @(negedge clockIn);
    resetIn = 1'b1;
    idle(6);

    // Randomised transactions
    for (int t = 0; t < 60; t++) begin
      sz   = 2'($urandom_range(1, 3));
      ld   = 1'($urandom_range(0, 1));
      addr = $urandom();
      if ($urandom_range(0, 3) == 0) addr[17:16] = 2'b11;
      if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      gm   = $urandom() | $urandom();
      im   = $urandom() & $urandom();
      clr  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
      do_txn(sz, ld, addr, $urandom(), gm, im, clr, 1'($urandom_range(0, 9) == 0), done_edge);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
